// File: rtl/pragmatic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pragmatic_pkg
// Purpose  : Shared types, width helpers and saturation check for the
//            Pragmatic-style bit-serial MAC.
// Revision : 1.0
// ============================================================================
package pragmatic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int c_DEF_DATA_WIDTH = 8;
    localparam int c_DEF_VEC_LENGTH = 8;
    localparam int c_DEF_IDX_WIDTH  = $clog2(c_DEF_DATA_WIDTH);
    localparam int c_DEF_TERM_WIDTH = 2 * c_DEF_DATA_WIDTH;
    localparam int c_DEF_TREE_WIDTH = 2 * c_DEF_DATA_WIDTH + $clog2(c_DEF_VEC_LENGTH);
    localparam int c_SAT_W          = 64;

    function automatic int idx_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

    function automatic int term_width(input int dw);
        return 2 * dw;
    endfunction

    function automatic int tree_width(input int dw, input int vl);
        return 2 * dw + $clog2(vl);
    endfunction

    // True when v lies outside the signed range of a w-bit result.
    function automatic logic sat_clips(input logic signed [c_SAT_W-1:0] v, input int w);
        logic signed [c_SAT_W-1:0] hi;
        logic signed [c_SAT_W-1:0] lo;
        hi = ({{(c_SAT_W-1){1'b0}}, 1'b1} << (w - 1)) - 1;
        lo = ~hi;
        return (v > hi) || (v < lo);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pragmatic_term_encoder.sv
`default_nettype none
// ============================================================================
// Module   : pragmatic_term_encoder
// Purpose  : Finds the lowest set bit of a weight magnitude and strips it.
// Revision : 1.0
// ============================================================================
module pragmatic_term_encoder #(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = 3
) (
    input  logic [DATA_WIDTH-1:0] mag,
    output logic [IDX_WIDTH-1:0]  p,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] next_mag
);

    always_comb begin
        p = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (mag[i]) p = IDX_WIDTH'(i);
        end
    end

    assign valid    = |mag;
    assign next_mag = mag & (mag - DATA_WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/pragmatic_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : pragmatic_mac_seq
// Purpose  : Self-sequencing bit-serial dot-product unit, one essential
//            weight term per lane per cycle, saturated result handshake.
// Revision : 1.0
// ============================================================================
module pragmatic_mac_seq
    import pragmatic_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int VEC_LENGTH   = 8,
    parameter int ACC_WIDTH    = 2 * DATA_WIDTH + 8,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic signed [DATA_WIDTH-1:0]   act_in [VEC_LENGTH],
    input  logic signed [DATA_WIDTH-1:0]   wgt_in [VEC_LENGTH],
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [RESULT_WIDTH-1:0] result,
    output logic                           result_sat,
    output logic [15:0]                    term_cycles
);

    localparam int c_IDX_W  = idx_width(DATA_WIDTH);
    localparam int c_TERM_W = term_width(DATA_WIDTH);
    localparam int c_TREE_W = tree_width(DATA_WIDTH, VEC_LENGTH);
    localparam logic [RESULT_WIDTH-1:0] c_RES_MAX = {1'b0, {(RESULT_WIDTH-1){1'b1}}};
    localparam logic [RESULT_WIDTH-1:0] c_RES_MIN = {1'b1, {(RESULT_WIDTH-1){1'b0}}};

    state_t                         r_state;
    state_t                         w_state_next;
    logic signed [DATA_WIDTH-1:0]   r_act [VEC_LENGTH];
    logic [DATA_WIDTH-1:0]          r_mag [VEC_LENGTH];
    logic                           r_neg [VEC_LENGTH];
    logic                           r_last;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic [15:0]                    r_term_cycles;
    logic signed [RESULT_WIDTH-1:0] r_result;
    logic                           r_result_sat;

    logic [DATA_WIDTH-1:0]          w_in_mag   [VEC_LENGTH];
    logic [DATA_WIDTH-1:0]          w_next_mag [VEC_LENGTH];
    logic [c_IDX_W-1:0]             w_p        [VEC_LENGTH];
    logic signed [c_TERM_W-1:0]     w_term     [VEC_LENGTH];
    logic [VEC_LENGTH-1:0]          w_in_nz;
    logic [VEC_LENGTH-1:0]          w_lane_busy;
    logic [VEC_LENGTH-1:0]          w_next_nz;
    logic signed [c_TREE_W-1:0]     w_tree_sum;
    logic signed [ACC_WIDTH-1:0]    w_acc_next;
    logic                           w_clip;
    logic [RESULT_WIDTH-1:0]        w_res_value;
    logic                           w_accept;
    logic                           w_release;

    assign w_accept  = in_valid && in_ready;
    assign w_release = out_valid && out_ready;

    generate
        for (genvar g = 0; g < VEC_LENGTH; g++) begin : g_lane
            logic signed [c_TERM_W-1:0] w_shifted;

            // -2^(N-1) negates to itself, which is the correct unsigned magnitude.
            assign w_in_mag[g] = wgt_in[g][DATA_WIDTH-1] ? $unsigned(-wgt_in[g])
                                                         : $unsigned(wgt_in[g]);
            assign w_in_nz[g]  = |wgt_in[g];

            pragmatic_term_encoder #(
                .DATA_WIDTH (DATA_WIDTH),
                .IDX_WIDTH  (c_IDX_W)
            ) u_enc (
                .mag      (r_mag[g]),
                .p        (w_p[g]),
                .valid    (w_lane_busy[g]),
                .next_mag (w_next_mag[g])
            );

            assign w_next_nz[g] = |w_next_mag[g];
            assign w_shifted    = c_TERM_W'(r_act[g]) <<< w_p[g];
            assign w_term[g]    = !w_lane_busy[g] ? '0 : (r_neg[g] ? -w_shifted : w_shifted);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_act[g] <= '0;
                    r_mag[g] <= '0;
                    r_neg[g] <= 1'b0;
                end else if (w_accept) begin
                    r_act[g] <= act_in[g];
                    r_mag[g] <= w_in_mag[g];
                    r_neg[g] <= wgt_in[g][DATA_WIDTH-1];
                end else if (r_state == RUN) begin
                    r_mag[g] <= w_next_mag[g];
                end
            end
        end
    endgenerate

    always_comb begin
        w_tree_sum = '0;
        for (int i = 0; i < VEC_LENGTH; i++) begin
            w_tree_sum = w_tree_sum + c_TREE_W'(w_term[i]);
        end
    end

    assign w_acc_next  = (r_state == RUN) ? r_acc + ACC_WIDTH'(w_tree_sum) : r_acc;
    assign w_clip      = sat_clips(c_SAT_W'(w_acc_next), RESULT_WIDTH);
    assign w_res_value = !w_clip ? w_acc_next[RESULT_WIDTH-1:0]
                                 : (w_acc_next[ACC_WIDTH-1] ? c_RES_MIN : c_RES_MAX);

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (|w_in_nz)     w_state_next = RUN;
                    else if (in_last) w_state_next = OUT;
                end
            end
            RUN: begin
                if (!(|w_next_nz)) w_state_next = r_last ? OUT : IDLE;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_last        <= 1'b0;
            r_acc         <= '0;
            r_term_cycles <= '0;
            r_result      <= '0;
            r_result_sat  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) r_last <= in_last;
            if (r_state == RUN) begin
                r_acc <= w_acc_next;
                if (r_term_cycles != 16'hFFFF) r_term_cycles <= r_term_cycles + 16'd1;
            end
            // Capture the result once, on entry to OUT, so it holds under backpressure.
            if (w_state_next == OUT && r_state != OUT) begin
                r_result     <= w_res_value;
                r_result_sat <= w_clip;
            end
            if (w_release) begin
                r_acc         <= '0;
                r_term_cycles <= '0;
            end
        end
    end

    assign result      = r_result;
    assign result_sat  = r_result_sat;
    assign term_cycles = r_term_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pragmatic_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pragmatic_mac_seq
// Purpose  : Self-checking bench for pragmatic_mac_seq against a dot-product
//            reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pragmatic_mac_seq;

    localparam int DW = 8;
    localparam int VL = 8;
    localparam int AW = 2 * DW + 8;
    localparam int RW = 2 * DW;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic signed [DW-1:0] act_in [VL];
    logic signed [DW-1:0] wgt_in [VL];
    logic                 out_valid;
    logic                 out_ready;
    logic signed [RW-1:0] result;
    logic                 result_sat;
    logic [15:0]          term_cycles;

    int     n_checks = 0;
    int     n_errors = 0;
    longint m_acc    = 0;
    int     m_terms  = 0;

    always #5 clk = ~clk;

    pragmatic_mac_seq #(
        .DATA_WIDTH   (DW),
        .VEC_LENGTH   (VL),
        .ACC_WIDTH    (AW),
        .RESULT_WIDTH (RW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .act_in      (act_in),
        .wgt_in      (wgt_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_sat  (result_sat),
        .term_cycles (term_cycles)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int popcount_abs(input logic signed [DW-1:0] w);
        int m;
        int c;
        m = (w < 0) ? -int'(w) : int'(w);
        c = 0;
        while (m != 0) begin
            c += m & 1;
            m = m >> 1;
        end
        return c;
    endfunction

    task automatic set_all(input int a, input int w);
        for (int i = 0; i < VL; i++) begin
            act_in[i] = DW'(a);
            wgt_in[i] = DW'(w);
        end
    endtask

    // Offers one vector, then counts RUN cycles until the unit is idle or presenting.
    task automatic send_vec(input bit last, input string tag);
        longint dot;
        int     exp_cyc;
        int     n;
        int     cyc;
        dot     = 0;
        exp_cyc = 0;
        for (int i = 0; i < VL; i++) begin
            dot += longint'(act_in[i]) * longint'(wgt_in[i]);
            if (popcount_abs(wgt_in[i]) > exp_cyc) exp_cyc = popcount_abs(wgt_in[i]);
        end
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_accept_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        cyc = 0;
        while (!in_ready && !out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_run_cycles"}, cyc, exp_cyc);
        m_acc   += dot;
        m_terms += exp_cyc;
        if (last) check({tag, "_out_valid"}, out_valid, 1);
        else      check({tag, "_ready_again"}, in_ready, 1);
    endtask

    task automatic collect(input int hold, input string tag);
        longint lim;
        longint exp_res;
        int     exp_sat;
        lim     = longint'(1) <<< (RW - 1);
        exp_sat = (m_acc > lim - 1 || m_acc < -lim) ? 1 : 0;
        exp_res = (m_acc > lim - 1) ? lim - 1 : ((m_acc < -lim) ? -lim : m_acc);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_result_sat"}, result_sat, exp_sat);
        check({tag, "_term_cycles"}, term_cycles, m_terms);
        out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, "_hold_result"}, result, exp_res);
            check({tag, "_hold_in_ready"}, in_ready, 0);
            check({tag, "_hold_out_valid"}, out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_released"}, out_valid, 0);
        check({tag, "_idle_ready"}, in_ready, 1);
        check({tag, "_terms_cleared"}, term_cycles, 0);
        m_acc   = 0;
        m_terms = 0;
    endtask

    initial begin
        int n_vec;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        set_all(0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_term_cycles", term_cycles, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        set_all(3, 5);
        send_vec(1'b1, "basic");
        collect(0, "basic");

        set_all(-128, -128);
        send_vec(1'b1, "extreme_neg");
        collect(0, "extreme_neg");

        set_all(0, 0);
        act_in[0] = 8'sd7;
        wgt_in[0] = -8'sd1;
        act_in[1] = -8'sd2;
        wgt_in[1] = 8'sd127;
        send_vec(1'b1, "mixed");
        collect(0, "mixed");

        for (int i = 0; i < VL; i++) begin
            act_in[i] = DW'($urandom_range(255, 0));
            wgt_in[i] = '0;
        end
        send_vec(1'b0, "zero_skip_v1");
        set_all(1, 1);
        send_vec(1'b1, "zero_skip_v2");
        collect(0, "zero_skip");

        set_all(127, 127);
        send_vec(1'b0, "multi_v1");
        send_vec(1'b0, "multi_v2");
        send_vec(1'b1, "multi_v3");
        collect(5, "multi");

        // Reset pulse in the third RUN cycle of a 7-term vector.
        set_all(5, -127);
        in_valid = 1'b1;
        in_last  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("mid_run_busy", in_ready, 0);
        check("mid_run_terms", term_cycles, 2);
        reset = 1'b1;
        #1;
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_terms", term_cycles, 0);
        check("async_rst_result", result, 0);
        check("async_rst_sat", result_sat, 0);
        #2;
        reset = 1'b0;
        m_acc   = 0;
        m_terms = 0;
        @(posedge clk); #1;
        set_all(2, 3);
        send_vec(1'b1, "post_reset");
        collect(0, "post_reset");

        for (int t = 0; t < 8; t++) begin
            n_vec = int'($urandom_range(4, 1));
            for (int v = 0; v < n_vec; v++) begin
                for (int i = 0; i < VL; i++) begin
                    act_in[i] = DW'($urandom_range(255, 0));
                    wgt_in[i] = ($urandom_range(5, 0) == 0) ? '0 : DW'($urandom_range(255, 0));
                end
                send_vec(v == n_vec - 1, "random");
            end
            collect(int'($urandom_range(3, 0)), "random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
